// File: rtl/frame_sync_ctrl.sv
// Frame-alignment controller: hunts for a sync word, verifies it, then holds lock
// with a flywheel that tolerates up to MISS_MAX-1 consecutive missed sync words.
module frame_sync_ctrl #(
  parameter int FRAME_LEN  = 64,
  parameter int VERIFY_CNT = 2,
  parameter int MISS_MAX   = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 hit,
  output logic                 det_en,
  output logic                 det_clr,
  output logic                 locked,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] bit_pos,
  output logic                 frame_start,
  output logic                 sync_err,
  output logic                 lock_lost
);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    VERIFY   = 2'd1,
    LOCKED   = 2'd2,
    FLYWHEEL = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_POS = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] VER_TGT  = CNT_WIDTH'(VERIFY_CNT);
  localparam logic [CNT_WIDTH-1:0] MISS_TGT = CNT_WIDTH'(MISS_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic [CNT_WIDTH-1:0] ver_q, ver_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;
  logic                 fs_d, se_d, ll_d, clr_d;
  logic                 checkpoint;

  assign checkpoint = (pos_q == LAST_POS);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    ver_d   = ver_q;
    miss_d  = miss_q;
    fs_d    = 1'b0;
    se_d    = 1'b0;
    ll_d    = 1'b0;
    clr_d   = 1'b0;
    if (en) begin
      if (state_q != HUNT) begin
        pos_d = checkpoint ? '0 : pos_q + ONE;
      end
      unique case (state_q)
        HUNT: begin
          if (hit) begin
            state_d = VERIFY;
            pos_d   = '0;
            ver_d   = '0;
          end
        end
        VERIFY: begin
          if (checkpoint) begin
            if (hit) begin
              ver_d = ver_q + ONE;
              if (ver_q + ONE == VER_TGT) begin
                state_d = LOCKED;
                fs_d    = 1'b1;
              end
            end else begin
              state_d = HUNT;
              se_d    = 1'b1;
              clr_d   = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (checkpoint) begin
            if (hit) begin
              fs_d = 1'b1;
            end else if (MISS_MAX > 1) begin
              // Keep framing on the local count while the sync word is absent.
              state_d = FLYWHEEL;
              miss_d  = ONE;
              se_d    = 1'b1;
              fs_d    = 1'b1;
            end else begin
              state_d = HUNT;
              ll_d    = 1'b1;
              clr_d   = 1'b1;
            end
          end
        end
        FLYWHEEL: begin
          if (checkpoint) begin
            if (hit) begin
              state_d = LOCKED;
              miss_d  = '0;
              fs_d    = 1'b1;
            end else if (miss_q + ONE == MISS_TGT) begin
              state_d = HUNT;
              ll_d    = 1'b1;
              clr_d   = 1'b1;
            end else begin
              miss_d = miss_q + ONE;
              se_d   = 1'b1;
              fs_d   = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
      // Every entry into HUNT restarts position and both counters.
      if (state_d == HUNT) begin
        pos_d  = '0;
        ver_d  = '0;
        miss_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      pos_q       <= '0;
      ver_q       <= '0;
      miss_q      <= '0;
      det_en      <= 1'b0;
      det_clr     <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      ver_q       <= ver_d;
      miss_q      <= miss_d;
      det_en      <= ~clr_d;
      det_clr     <= clr_d;
      locked      <= (state_d == LOCKED) || (state_d == FLYWHEEL);
      frame_start <= fs_d;
      sync_err    <= se_d;
      lock_lost   <= ll_d;
    end
  end

  assign state   = state_q;
  assign bit_pos = pos_q;

endmodule
